gyro_spi_responder: RTL and testbench
=====================================

Name: gyro_spi_responder

Overview:
SPI slave model of the 3-axis gyro PMOD (L3G4200D-style register interface). It answers the byte-level SPI master that our gyro FSM drives, so the full gyro read path can run in loopback and simulation without the physical PMOD. It decodes the command byte, serves a small register file with auto-increment burst reads, and accepts control-register writes. Axis and temperature values come from injectable inputs.

Parameters:
WHO_AM_I_VAL, 8'hD3, value returned at address 0x0F
CTRL_REG1_RST, 8'h07, reset value of CTRL_REG1 (0x20)
SYNC_STAGES, 2, synchronizer depth for sclk/mosi/ss (≥2)

Ports:
clk  input  1  system clock; must run ≥8x sclk
rst  input  1  asynchronous, active-high reset
sclk  input  1  SPI clock from master, mode 3 (idles high)
mosi  input  1  master-out data
ss  input  1  slave select, active low
miso  output  1  slave-out data; 0 when ss high
x_in, y_in, z_in  input  16 each  angular-rate values to serve
temp_in  input  8  temperature value to serve
ctrl_reg1  output  8  current CTRL_REG1 contents
ctrl_reg2..ctrl_reg5  output  8 each  current CTRL_REG2..5 contents
wr_strobe  output  1  one-clk pulse on every committed register write
wr_addr  output  6  address of last committed write

Behaviour:
- Reset (async): ctrl_reg1=CTRL_REG1_RST, ctrl_reg2..5=0, miso=0, wr_strobe=0, wr_addr=0; FSM->IDLE; bit counter=0; snapshot=0. Reset mid-transaction aborts it; no write commits.
- sclk, mosi, ss pass through SYNC_STAGES flops. Edges detected on the synchronized sclk. All logic runs on clk.
- FSM states: IDLE, CMD, DATA.
- IDLE: waits for ss falling. On ss falling: bit_cnt=0, go to CMD, and snapshot x_in/y_in/z_in/temp_in into a 56-bit holding register so a burst reads coherent data.
- Bit timing (mode 3): shift mosi in MSB-first on each sclk rising edge; drive miso from shift-out MSB on each sclk falling edge.
- CMD: after the 8th rising edge, latch rw=bit7 (1=read), ms=bit6 (1=auto-increment), addr=bits5:0, then go to DATA. If rw=1, load the shift-out register with reg[addr] in the same clk, so bit7 appears on the first falling edge of the next byte.
- DATA, read: at every 8th rising edge, if ms=1 then addr<=addr+1 (wrapping 0x3F->0x00) and load reg[new addr]; if ms=0, addr is unchanged and the same register is reloaded.
- DATA, write: at every 8th rising edge, if addr is in 0x20..0x24, update the register and pulse wr_strobe for 1 clk with wr_addr=addr. Otherwise ignore the write, with no strobe. Address advances as for reads.
- Commit latency: register update ≤ SYNC_STAGES+2 clk after the 8th sclk rising edge at the pins.
- Register map (read): 0x0F=WHO_AM_I_VAL; 0x20–0x24=ctrl_reg1..5; 0x26=temp snapshot; 0x28=X[7:0], 0x29=X[15:8], 0x2A=Y[7:0], 0x2B=Y[15:8], 0x2C=Z[7:0], 0x2D=Z[15:8]. All other addresses read 8'h00.
- During CMD, miso=0.
- ss rising at any point returns the FSM to IDLE and forces miso=0. A partial byte (<8 bits) is discarded with no write. Burst state does not carry into the next transaction.
- ss falling while already selected (glitch-free master never does this) is treated as a fresh transaction start.
- Simultaneous sclk edge and ss rising in the same synchronized clk: ss wins, and the byte is discarded unless it was already complete.
- Input changes on x_in/y_in/z_in/temp_in during a transaction do not affect served data until the next ss falling.

Test Plan:
- Reset: assert rst mid-idle -> ctrl_reg1=8'h07, ctrl_reg2..5=0, miso=0.
- Write CTRL_REG1: ss low, send 8'h20, 8'h0F, ss high -> ctrl_reg1=8'h0F, single wr_strobe with wr_addr=6'h20.
- WHO_AM_I read: send 8'h8F, 8'h00 -> second byte on miso = 8'hD3.
- Burst axis read: x_in=16'h1234, y_in=16'hABCD, z_in=16'h00FF; send 8'hE8 then six 8'h00 -> miso bytes 34,12,CD,AB,FF,00. Changing x_in to 16'h5555 mid-burst does not alter the output.
- Temp and non-increment read: temp_in=8'h19; send 8'hA6, 8'h00, 8'h00 -> both data bytes = 8'h19 (ms=0 holds addr).
- Aborts and ignored writes: raise ss after 4 data bits of write 8'h21 -> ctrl_reg2 unchanged, no wr_strobe. Write 8'h0F,8'h55 -> no strobe and WHO_AM_I still reads 8'hD3. Burst read from 8'hFF wraps -> reads 0x3F (8'h00) then 0x00 (8'h00).

Source files
------------

// File: rtl/gyro_spi_responder.sv
// gyro_spi_responder: SPI mode-3 slave emulating an L3G4200D-style gyro register file,
// with snapshot-coherent burst reads and control-register writes.
module gyro_spi_responder #(
    parameter logic [7:0] WHO_AM_I_VAL  = 8'hD3,
    parameter logic [7:0] CTRL_REG1_RST = 8'h07,
    parameter int         SYNC_STAGES   = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        sclk,
    input  logic        mosi,
    input  logic        ss,
    output logic        miso,
    input  logic [15:0] x_in,
    input  logic [15:0] y_in,
    input  logic [15:0] z_in,
    input  logic [7:0]  temp_in,
    output logic [7:0]  ctrl_reg1,
    output logic [7:0]  ctrl_reg2,
    output logic [7:0]  ctrl_reg3,
    output logic [7:0]  ctrl_reg4,
    output logic [7:0]  ctrl_reg5,
    output logic        wr_strobe,
    output logic [5:0]  wr_addr
);
    typedef enum logic [1:0] {IDLE, CMD, DATA} state_t;

    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d, mosi_sync_q, mosi_sync_d, ss_sync_q, ss_sync_d;
    logic                   sclk_prev_q, sclk_prev_d, ss_prev_q, ss_prev_d;
    logic [2:0]             bit_cnt_q, bit_cnt_d;
    logic [7:0]             rx_q, rx_d, tx_q, tx_d;
    logic [5:0]             addr_q, addr_d, wr_addr_q, wr_addr_d;
    logic                   rw_q, rw_d, ms_q, ms_d;
    logic                   miso_q, miso_d, wr_strobe_q, wr_strobe_d;
    logic [55:0]            snap_q, snap_d;
    logic [4:0][7:0]        ctrl_q, ctrl_d;

    logic       sclk_s, mosi_s, ss_s, rise, fall, ss_fall, byte_done, in_ctrl;
    logic [7:0] rx_byte, rd_data;
    logic [5:0] ld_addr;

    assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
    assign ss_s      = ss_sync_q[SYNC_STAGES-1];
    assign rise      = sclk_s & ~sclk_prev_q;
    assign fall      = ~sclk_s & sclk_prev_q;
    assign ss_fall   = ~ss_s & ss_prev_q;
    assign rx_byte   = {rx_q[6:0], mosi_s};
    assign byte_done = rise && (bit_cnt_q == 3'd7);
    assign in_ctrl   = (addr_q >= 6'h20) && (addr_q <= 6'h24);
    // Address whose contents get loaded into the shifter when the current byte completes
    assign ld_addr   = (state_q == CMD) ? rx_byte[5:0] : (ms_q ? addr_q + 6'd1 : addr_q);

    // snap layout: {x[15:0], y[15:0], z[15:0], temp[7:0]}
    always_comb begin
        rd_data = (ld_addr == 6'h0F) ? WHO_AM_I_VAL :
                  (ld_addr >= 6'h20 && ld_addr <= 6'h24) ? ctrl_q[ld_addr[2:0]] :
                  (ld_addr == 6'h26) ? snap_q[7:0] :
                  (ld_addr == 6'h28) ? snap_q[47:40] :
                  (ld_addr == 6'h29) ? snap_q[55:48] :
                  (ld_addr == 6'h2A) ? snap_q[31:24] :
                  (ld_addr == 6'h2B) ? snap_q[39:32] :
                  (ld_addr == 6'h2C) ? snap_q[15:8] :
                  (ld_addr == 6'h2D) ? snap_q[23:16] : 8'h00;
    end

    always_comb begin
        sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], sclk};
        mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], mosi};
        ss_sync_d   = {ss_sync_q[SYNC_STAGES-2:0], ss};
        sclk_prev_d = sclk_s;
        ss_prev_d   = ss_s;
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        rx_d        = rx_q;
        tx_d        = tx_q;
        addr_d      = addr_q;
        rw_d        = rw_q;
        ms_d        = ms_q;
        miso_d      = miso_q;
        snap_d      = snap_q;
        ctrl_d      = ctrl_q;
        wr_strobe_d = 1'b0;
        wr_addr_d   = wr_addr_q;
        if (ss_fall) begin
            state_d   = CMD;
            bit_cnt_d = 3'd0;
            tx_d      = 8'h00;
            miso_d    = 1'b0;
            snap_d    = {x_in, y_in, z_in, temp_in};
        end else if (ss_s) begin
            // Deselect wins over any simultaneous sclk edge; partial bytes are dropped
            state_d   = IDLE;
            bit_cnt_d = 3'd0;
            miso_d    = 1'b0;
        end else if (state_q != IDLE) begin
            if (rise) begin
                rx_d      = rx_byte;
                bit_cnt_d = bit_cnt_q + 3'd1;
            end
            if (fall && state_q == DATA) begin
                miso_d = tx_q[7];
                tx_d   = {tx_q[6:0], 1'b0};
            end
            if (byte_done && state_q == CMD) begin
                rw_d    = rx_byte[7];
                ms_d    = rx_byte[6];
                addr_d  = rx_byte[5:0];
                state_d = DATA;
                tx_d    = rx_byte[7] ? rd_data : 8'h00;
            end else if (byte_done) begin
                addr_d = ld_addr;
                tx_d   = rw_q ? rd_data : 8'h00;
                if (!rw_q && in_ctrl) begin
                    ctrl_d[addr_q[2:0]] = rx_byte;
                    wr_strobe_d         = 1'b1;
                    wr_addr_d           = addr_q;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            sclk_sync_q <= '1;
            mosi_sync_q <= '0;
            ss_sync_q   <= '1;
            sclk_prev_q <= 1'b1;
            ss_prev_q   <= 1'b1;
            bit_cnt_q   <= 3'd0;
            rx_q        <= 8'h00;
            tx_q        <= 8'h00;
            addr_q      <= 6'h00;
            rw_q        <= 1'b0;
            ms_q        <= 1'b0;
            miso_q      <= 1'b0;
            snap_q      <= 56'h0;
            ctrl_q      <= {32'h0, CTRL_REG1_RST};
            wr_strobe_q <= 1'b0;
            wr_addr_q   <= 6'h00;
        end else begin
            state_q     <= state_d;
            sclk_sync_q <= sclk_sync_d;
            mosi_sync_q <= mosi_sync_d;
            ss_sync_q   <= ss_sync_d;
            sclk_prev_q <= sclk_prev_d;
            ss_prev_q   <= ss_prev_d;
            bit_cnt_q   <= bit_cnt_d;
            rx_q        <= rx_d;
            tx_q        <= tx_d;
            addr_q      <= addr_d;
            rw_q        <= rw_d;
            ms_q        <= ms_d;
            miso_q      <= miso_d;
            snap_q      <= snap_d;
            ctrl_q      <= ctrl_d;
            wr_strobe_q <= wr_strobe_d;
            wr_addr_q   <= wr_addr_d;
        end
    end

    assign miso      = miso_q;
    assign ctrl_reg1 = ctrl_q[0];
    assign ctrl_reg2 = ctrl_q[1];
    assign ctrl_reg3 = ctrl_q[2];
    assign ctrl_reg4 = ctrl_q[3];
    assign ctrl_reg5 = ctrl_q[4];
    assign wr_strobe = wr_strobe_q;
    assign wr_addr   = wr_addr_q;
endmodule

// File: tb/tb_gyro_spi_responder.sv
// tb_gyro_spi_responder: drives SPI mode-3 transactions into the gyro responder and
// checks served bytes against a scoreboard of expected read data.
module tb_gyro_spi_responder;
    logic        clk = 1'b0, rst = 1'b1, sclk = 1'b1, mosi = 1'b0, ss = 1'b1;
    logic        miso, wr_strobe;
    logic [15:0] x_in = 16'h0, y_in = 16'h0, z_in = 16'h0;
    logic [7:0]  temp_in = 8'h0;
    logic [7:0]  ctrl_reg1, ctrl_reg2, ctrl_reg3, ctrl_reg4, ctrl_reg5;
    logic [5:0]  wr_addr;

    int          vectors = 0, errors = 0, n_stb = 0, stb0;
    logic [7:0]  exp_q[$];
    logic [7:0]  rx;

    gyro_spi_responder dut (
        .clk(clk), .rst(rst), .sclk(sclk), .mosi(mosi), .ss(ss), .miso(miso),
        .x_in(x_in), .y_in(y_in), .z_in(z_in), .temp_in(temp_in),
        .ctrl_reg1(ctrl_reg1), .ctrl_reg2(ctrl_reg2), .ctrl_reg3(ctrl_reg3),
        .ctrl_reg4(ctrl_reg4), .ctrl_reg5(ctrl_reg5),
        .wr_strobe(wr_strobe), .wr_addr(wr_addr)
    );

    always #5 clk = ~clk;
    always @(posedge clk) if (wr_strobe) n_stb <= n_stb + 1;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Master side: data out on the falling edge, miso sampled just before the rising edge
    task automatic spi_bits(input logic [7:0] tx, input int nb, output logic [7:0] r);
        r = 8'h00;
        for (int i = 7; i > 7 - nb; i--) begin
            sclk = 1'b0;
            mosi = tx[i];
            #60;
            r = {r[6:0], miso};
            sclk = 1'b1;
            #60;
        end
    endtask

    task automatic ss_end();
        ss = 1'b1;
        #120;
        chk("miso_idle", {15'h0, miso}, 16'h0);
    endtask

    task automatic wr_txn(input logic [7:0] cmd, input logic [15:0] data, input int n);
        logic [7:0] r;
        ss = 1'b0;
        #60;
        spi_bits(cmd, 8, r);
        spi_bits(data[15:8], 8, r);
        if (n > 1) spi_bits(data[7:0], 8, r);
        ss_end();
    endtask

    task automatic rd_txn(input logic [7:0] cmd, input int n, input int chg);
        logic [7:0] r;
        ss = 1'b0;
        #60;
        spi_bits(cmd, 8, r);
        chk("cmd_miso", {8'h0, r}, 16'h0);
        for (int i = 0; i < n; i++) begin
            if (i == chg) x_in = 16'h5555;
            spi_bits(8'h00, 8, r);
            if (exp_q.size() == 0) chk("sb_underrun", 16'h1, 16'h0);
            else chk("miso_rd", {8'h0, r}, {8'h0, exp_q.pop_front()});
        end
        ss_end();
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_ctrl1", {8'h0, ctrl_reg1}, 16'h07);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_ctrl2_5", {ctrl_reg2 | ctrl_reg3, ctrl_reg4 | ctrl_reg5}, 16'h0);
        chk("rst_miso_stb", {14'h0, miso, wr_strobe}, 16'h0);
        chk("rst_wr_addr", {10'h0, wr_addr}, 16'h0);

        stb0 = n_stb;
        wr_txn(8'h20, 16'h0F00, 1);
        chk("wr_ctrl1", {8'h0, ctrl_reg1}, 16'h0F);
        chk("wr_ctrl1_stb", 16'(n_stb - stb0), 16'd1);
        chk("wr_ctrl1_addr", {10'h0, wr_addr}, 16'h20);

        stb0 = n_stb;
        wr_txn(8'h61, 16'hA1A2, 2);
        chk("wr_burst", {ctrl_reg2, ctrl_reg3}, 16'hA1A2);
        chk("wr_burst_stb", 16'(n_stb - stb0), 16'd2);
        chk("wr_burst_addr", {10'h0, wr_addr}, 16'h22);

        stb0 = n_stb;
        wr_txn(8'h64, 16'h5A77, 2);
        chk("wr_ctrl5_edge", {8'h0, ctrl_reg5}, 16'h5A);
        chk("wr_0x25_ignored", 16'(n_stb - stb0), 16'd1);
        chk("wr_ctrl5_addr", {10'h0, wr_addr}, 16'h24);

        exp_q.push_back(8'hD3);
        rd_txn(8'h8F, 1, -1);

        exp_q = '{8'h0F, 8'hA1, 8'hA2, 8'h00, 8'h5A};
        rd_txn(8'hE0, 5, -1);

        x_in = 16'h1234; y_in = 16'hABCD; z_in = 16'h00FF;
        exp_q = '{8'h34, 8'h12, 8'hCD, 8'hAB, 8'hFF, 8'h00};
        rd_txn(8'hE8, 6, 0);
        exp_q = '{8'h55, 8'h55};
        rd_txn(8'hA8, 2, -1);

        temp_in = 8'h19;
        exp_q = '{8'h19, 8'h19};
        rd_txn(8'hA6, 2, -1);

        stb0 = n_stb;
        ss = 1'b0;
        #60;
        spi_bits(8'h21, 8, rx);
        spi_bits(8'h3C, 4, rx);
        ss_end();
        chk("abort_ctrl2", {8'h0, ctrl_reg2}, 16'hA1);
        chk("abort_no_stb", 16'(n_stb - stb0), 16'd0);

        stb0 = n_stb;
        wr_txn(8'h0F, 16'h5500, 1);
        chk("ro_no_stb", 16'(n_stb - stb0), 16'd0);
        exp_q.push_back(8'hD3);
        rd_txn(8'h8F, 1, -1);

        exp_q = '{8'h00, 8'h00, 8'h00};
        rd_txn(8'hFF, 3, -1);
        chk("sb_drained", 16'(exp_q.size()), 16'd0);

        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("rst2_ctrl1", {8'h0, ctrl_reg1}, 16'h07);
        chk("rst2_ctrl2_5", {ctrl_reg2 | ctrl_reg3, ctrl_reg4 | ctrl_reg5}, 16'h0);
        chk("rst2_miso_addr", {9'h0, miso, wr_addr}, 16'h0);
        rst = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
